// File: rtl/spi_frame_avalon_bridge_pkg.sv
`default_nettype none
// ============================================================================
// spi_frame_avalon_bridge_pkg : shared types and frame-format constants
// Rev 1.0
// ============================================================================
package spi_frame_avalon_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_WRITE = 3'd2,
        ST_READ  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int HDR_LEN       = 1;
    localparam int REC_LEN       = 6;
    localparam int REC_REG_OFS   = 0;
    localparam int REC_MOTOR_OFS = 1;
    localparam int REC_DATA_OFS  = 2;

    // Status registers polled per motor, in read-back order
    function automatic logic [7:0] rd_reg_id(input logic [2:0] idx);
        case (idx)
            3'd0:    rd_reg_id = 8'h0B;
            3'd1:    rd_reg_id = 8'h0C;
            3'd2:    rd_reg_id = 8'h0E;
            3'd3:    rd_reg_id = 8'h0D;
            3'd4:    rd_reg_id = 8'h0F;
            default: rd_reg_id = 8'h00;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_frame_avalon_bridge_avalon_seq_master.sv
`default_nettype none
// ============================================================================
// spi_frame_avalon_bridge_avalon_seq_master : single-transfer Avalon-MM master
// Rev 1.0
// ============================================================================
module spi_frame_avalon_bridge_avalon_seq_master (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_read,
    input  logic [15:0] cmd_address,
    input  logic [31:0] cmd_writedata,
    output logic [15:0] av_address,
    output logic        av_write,
    output logic [31:0] av_writedata,
    output logic        av_read,
    input  logic [31:0] av_readdata,
    input  logic        av_waitrequest,
    output logic        done,
    output logic [31:0] rdata
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            av_address   <= '0;
            av_write     <= 1'b0;
            av_writedata <= '0;
            av_read      <= 1'b0;
            done         <= 1'b0;
            rdata        <= '0;
        end else begin
            done <= 1'b0;
            if (av_write || av_read) begin
                // Command is held untouched until the slave stops stalling
                if (!av_waitrequest) begin
                    av_write <= 1'b0;
                    av_read  <= 1'b0;
                    done     <= 1'b1;
                    if (av_read) begin
                        rdata <= av_readdata;
                    end
                end
            end else if (start) begin
                av_address   <= cmd_address;
                av_writedata <= cmd_writedata;
                av_write     <= ~is_read;
                av_read      <= is_read;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_frame_avalon_bridge.sv
`default_nettype none
// ============================================================================
// spi_frame_avalon_bridge : SPI frame capture -> Avalon writes -> status readback
// Rev 1.0
// ============================================================================
module spi_frame_avalon_bridge
    import spi_frame_avalon_bridge_pkg::*;
#(
    parameter int NUM_MOTORS  = 4,
    parameter int MAX_RECORDS = 13,
    parameter int RD_REGS     = 5
) (
    input  logic        iCLK,
    input  logic        iRESET,
    input  logic        iFRAME_ACTIVE,
    input  logic [7:0]  iRX_BYTE,
    input  logic        iRX_VALID,
    output logic [15:0] oAV_ADDRESS,
    output logic        oAV_WRITE,
    output logic [31:0] oAV_WRITEDATA,
    output logic        oAV_READ,
    input  logic [31:0] iAV_READDATA,
    input  logic        iAV_WAITREQUEST,
    input  logic [6:0]  iTX_INDEX,
    output logic [7:0]  oTX_BYTE,
    output logic        oTX_READY,
    output logic        oBUSY,
    output logic [7:0]  oERR_CNT
);

    localparam int RX_DEPTH = HDR_LEN + REC_LEN * MAX_RECORDS;
    localparam int CNT_W    = $clog2(RX_DEPTH + 1);
    localparam int TX_WORDS = NUM_MOTORS * RD_REGS;
    localparam int TX_BYTES = 4 * TX_WORDS;
    localparam int TXW_W    = $clog2(TX_WORDS);

    state_t             state;
    logic               frame_q;
    logic [7:0]         rx_mem [RX_DEPTH];
    logic [31:0]        tx_word [TX_WORDS];
    logic [CNT_W-1:0]   rx_cnt;
    logic               rx_ovf;
    logic [7:0]         rec_idx;
    logic [7:0]         motor;
    logic [2:0]         reg_idx;
    logic               pending;
    logic               start;
    logic               is_read;
    logic [15:0]        cmd_address;
    logic [31:0]        cmd_writedata;
    logic               seq_done;
    logic [31:0]        seq_rdata;

    logic               w_rise;
    logic               w_fall;
    logic               w_store;
    logic               w_ovf_final;
    logic [CNT_W-1:0]   w_cnt_final;
    logic [15:0]        w_expect_len;
    logic               w_frame_ok;
    logic [CNT_W-1:0]   w_base;
    logic [15:0]        w_rec_addr;
    logic [31:0]        w_rec_data;
    logic               w_last_rec;
    logic               w_last_rd;
    logic [TXW_W-1:0]   w_tx_sel;
    logic [TXW_W-1:0]   w_rd_word;

    assign w_rise  = iFRAME_ACTIVE & ~frame_q;
    assign w_fall  = ~iFRAME_ACTIVE & frame_q;
    assign w_store = (state == ST_RECV) && iRX_VALID && (rx_cnt < CNT_W'(RX_DEPTH));

    // Count and overflow include a byte arriving on the same cycle as the falling edge
    assign w_cnt_final  = rx_cnt + CNT_W'(w_store);
    assign w_ovf_final  = rx_ovf | ((state == ST_RECV) && iRX_VALID && (rx_cnt == CNT_W'(RX_DEPTH)));
    assign w_expect_len = 16'(REC_LEN) * {8'd0, rx_mem[0]} + 16'(HDR_LEN);
    assign w_frame_ok   = !w_ovf_final && (rx_mem[0] >= 8'd1) && (rx_mem[0] <= 8'(MAX_RECORDS))
                          && (w_expect_len == 16'(w_cnt_final));

    assign w_base     = CNT_W'(HDR_LEN) + CNT_W'(REC_LEN) * CNT_W'(rec_idx);
    assign w_rec_addr = {rx_mem[w_base + CNT_W'(REC_REG_OFS)], rx_mem[w_base + CNT_W'(REC_MOTOR_OFS)]};
    assign w_rec_data = {rx_mem[w_base + CNT_W'(REC_DATA_OFS)],     rx_mem[w_base + CNT_W'(REC_DATA_OFS + 1)],
                         rx_mem[w_base + CNT_W'(REC_DATA_OFS + 2)], rx_mem[w_base + CNT_W'(REC_DATA_OFS + 3)]};
    assign w_last_rec = (rec_idx == rx_mem[0] - 8'd1);
    assign w_last_rd  = (reg_idx == 3'(RD_REGS - 1)) && (motor == 8'(NUM_MOTORS - 1));
    assign w_tx_sel   = TXW_W'(int'(motor) * RD_REGS + int'(reg_idx));
    assign w_rd_word  = TXW_W'(iTX_INDEX >> 2);

    assign oBUSY = (state == ST_WRITE) || (state == ST_READ);

    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            state         <= ST_IDLE;
            frame_q       <= 1'b0;
            rx_cnt        <= '0;
            rx_ovf        <= 1'b0;
            rec_idx       <= '0;
            motor         <= '0;
            reg_idx       <= '0;
            pending       <= 1'b0;
            start         <= 1'b0;
            is_read       <= 1'b0;
            cmd_address   <= '0;
            cmd_writedata <= '0;
            oTX_READY     <= 1'b0;
            oERR_CNT      <= '0;
        end else begin
            frame_q   <= iFRAME_ACTIVE;
            start     <= 1'b0;
            oTX_READY <= 1'b0;
            if (w_rise && oBUSY && (oERR_CNT != 8'hFF)) begin
                oERR_CNT <= oERR_CNT + 8'd1;
            end
            case (state)
                ST_IDLE: begin
                    if (w_rise) begin
                        state  <= ST_RECV;
                        rx_cnt <= '0;
                        rx_ovf <= 1'b0;
                    end
                end
                ST_RECV: begin
                    rx_cnt <= w_cnt_final;
                    rx_ovf <= w_ovf_final;
                    if (w_fall) begin
                        if (w_frame_ok) begin
                            state   <= ST_WRITE;
                            rec_idx <= '0;
                            pending <= 1'b0;
                        end else begin
                            state <= ST_IDLE;
                            if (oERR_CNT != 8'hFF) begin
                                oERR_CNT <= oERR_CNT + 8'd1;
                            end
                        end
                    end
                end
                ST_WRITE: begin
                    if (!pending) begin
                        start         <= 1'b1;
                        is_read       <= 1'b0;
                        cmd_address   <= w_rec_addr;
                        cmd_writedata <= w_rec_data;
                        pending       <= 1'b1;
                    end else if (seq_done) begin
                        pending <= 1'b0;
                        if (w_last_rec) begin
                            state   <= ST_READ;
                            motor   <= '0;
                            reg_idx <= '0;
                        end else begin
                            rec_idx <= rec_idx + 8'd1;
                        end
                    end
                end
                ST_READ: begin
                    if (!pending) begin
                        start         <= 1'b1;
                        is_read       <= 1'b1;
                        cmd_address   <= {rd_reg_id(reg_idx), motor};
                        cmd_writedata <= '0;
                        pending       <= 1'b1;
                    end else if (seq_done) begin
                        pending <= 1'b0;
                        if (w_last_rd) begin
                            state     <= ST_DONE;
                            oTX_READY <= 1'b1;
                        end else if (reg_idx == 3'(RD_REGS - 1)) begin
                            reg_idx <= '0;
                            motor   <= motor + 8'd1;
                        end else begin
                            reg_idx <= reg_idx + 3'd1;
                        end
                    end
                end
                ST_DONE: begin
                    state  <= w_rise ? ST_RECV : ST_IDLE;
                    rx_cnt <= '0;
                    rx_ovf <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Frame and readback storage are deliberately left out of reset
    always_ff @(posedge iCLK) begin
        if (w_store) begin
            rx_mem[rx_cnt] <= iRX_BYTE;
        end
        if ((state == ST_READ) && pending && seq_done) begin
            tx_word[w_tx_sel] <= seq_rdata;
        end
    end

    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            oTX_BYTE <= '0;
        end else if (iTX_INDEX < 7'(TX_BYTES)) begin
            case (iTX_INDEX[1:0])
                2'd0:    oTX_BYTE <= tx_word[w_rd_word][31:24];
                2'd1:    oTX_BYTE <= tx_word[w_rd_word][23:16];
                2'd2:    oTX_BYTE <= tx_word[w_rd_word][15:8];
                default: oTX_BYTE <= tx_word[w_rd_word][7:0];
            endcase
        end else begin
            oTX_BYTE <= '0;
        end
    end

    spi_frame_avalon_bridge_avalon_seq_master u_seq (
        .clk            (iCLK),
        .rst            (iRESET),
        .start          (start),
        .is_read        (is_read),
        .cmd_address    (cmd_address),
        .cmd_writedata  (cmd_writedata),
        .av_address     (oAV_ADDRESS),
        .av_write       (oAV_WRITE),
        .av_writedata   (oAV_WRITEDATA),
        .av_read        (oAV_READ),
        .av_readdata    (iAV_READDATA),
        .av_waitrequest (iAV_WAITREQUEST),
        .done           (seq_done),
        .rdata          (seq_rdata)
    );

endmodule
`default_nettype wire

// File: doc/spi_frame_avalon_bridge.md
Name: spi_frame_avalon_bridge

Overview:
Sits directly downstream of the SPI byte-slave on the MKR Vidor top level and directly upstream of the myocontrol Avalon slave.
- Collects one SAMD→FPGA frame of bytes.
- Validates the frame, then replays its write records as Avalon-MM writes.
- Reads back a fixed table of motor status registers into a transmit buffer for the next SPI frame.

Parameters:
NUM_MOTORS, 4, motors polled in read-back phase
MAX_RECORDS, 13, max write records per frame; rx buffer depth = 1+6*MAX_RECORDS bytes
RD_REGS, 5, status registers read per motor (ids 0x0B,0x0C,0x0E,0x0D,0x0F in that order)
TX_BYTES, 4*NUM_MOTORS*RD_REGS (80), tx buffer depth

Ports:
iCLK  in  1  system clock
iRESET  in  1  asynchronous active-high reset
iFRAME_ACTIVE  in  1  high while SAMD frame select is asserted
iRX_BYTE  in  8  received byte from SPI slave
iRX_VALID  in  1  one-cycle pulse, iRX_BYTE valid
oAV_ADDRESS  out  16  {reg_id, motor}
oAV_WRITE  out  1  Avalon write strobe
oAV_WRITEDATA  out  32  write data
oAV_READ  out  1  Avalon read strobe
iAV_READDATA  in  32  read data
iAV_WAITREQUEST  in  1  slave stall
iTX_INDEX  in  7  tx buffer byte select
oTX_BYTE  out  8  tx buffer byte, 1-cycle registered latency
oTX_READY  out  1  one-cycle pulse: tx buffer refreshed
oBUSY  out  1  high in WRITE/READ states
oERR_CNT  out  8  saturating count of discarded frames

Behaviour:
- Reset (async, any state): state=IDLE; all strobes 0; oAV_ADDRESS/WRITEDATA 0; oTX_BYTE 0; oTX_READY 0; oERR_CNT 0; tx buffer contents undefined-but-stable (not cleared).
- Frame format: byte0 = N record count; then N records of 6 bytes: reg_id, motor, data[31:24], [23:16], [15:8], [7:0] (big-endian).
- IDLE: rising edge of iFRAME_ACTIVE → RECV, byte counter 0.
- RECV: each iRX_VALID stores byte at counter, counter+1. Bytes beyond rx depth are not stored; overflow flag set.
- Falling edge of iFRAME_ACTIVE: valid iff no overflow, 1<=N<=MAX_RECORDS and count == 1+6*N.
  - Valid → WRITE, record idx 0.
  - Invalid → IDLE, oERR_CNT+1 (saturate 255).
  - iRX_VALID in the same cycle as the falling edge is counted.
- WRITE: drive address/data of record idx, oAV_WRITE=1. Hold all three unchanged while iAV_WAITREQUEST=1. On the cycle waitrequest=0 is sampled, the write completes; strobe drops next cycle (min 1 idle cycle between transfers). After record N-1 → READ, motor 0, reg 0.
- READ: drive address {reg_id, motor}, oAV_READ=1. Capture iAV_READDATA when waitrequest=0. Store big-endian at tx byte offset 4*(motor*RD_REGS+reg).
  - Order: reg inner loop, motor outer loop.
  - After the last read → DONE.
- DONE: pulse oTX_READY one cycle → IDLE.
- Frame-select rising edge while oBUSY: frame ignored entirely (no storage), oERR_CNT+1. Bridge completes the current transaction sequence.
- Readback of the tx buffer through iTX_INDEX is allowed any time. Index >= TX_BYTES returns 0.
- No combinational path from Avalon inputs to Avalon outputs.

Decomposition:
- Shared package: state enum; RD_REG_ID table constant (0x0B,0x0C,0x0E,0x0D,0x0F); record length 6; frame-format constants.
- One natural sub-module: avalon_seq_master. Owns the single-transfer write/read handshake, with start/done/is_read interface to the frame FSM.

Test Plan:
- Frame N=1, {0x03,0x02,0x00,0x00,0x01,0xF4}; slave no wait → exactly one write, addr 0x0302, data 0x000001F4. Then 20 reads, addrs 0x0B00,0x0C00,0x0E00,0x0D00,0x0F00,0x0B01… ending 0x0F03; oTX_READY pulses once.
- Slave holds waitrequest 3 cycles on every transfer → address/data/strobe stable across all 4 cycles, no duplicate transfer.
- Read data 0xDEADBEEF for addr 0x0B01 → tx bytes 20..23 = DE,AD,BE,EF.
- Frame N=2 with 12 bytes → no Avalon activity, oERR_CNT=1. Frame N=0 → oERR_CNT=2. 100-byte frame → oERR_CNT=3.
- New frame-select edge during READ → current sequence finishes normally, oERR_CNT+1, no writes from the new frame.
- iRESET asserted mid-WRITE with waitrequest high → oAV_WRITE=0 asynchronously, state IDLE. Next valid frame processes normally.
